// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the runtime-programmable toggle clock divider.
// Latency: none (types and constants only); no backpressure.
package clk_div_pkg;

    localparam int CNT_W_DEF        = 16;
    localparam int DEFAULT_HALF_DEF = 2;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with toggle output and registered one-cycle edge strobes.
// Latency: outputs update on the edge that ends a counted cycle; no backpressure.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             wrap_o,
    output logic             clk_out_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgl_q, tgl_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    assign wrap_o    = (cnt_q == half_i - ONE);
    assign clk_out_o = tgl_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

    always_comb begin
        cnt_d  = cnt_q;
        tgl_d  = tgl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            tgl_d = 1'b0;
        end else if (run_i) begin
            if (wrap_o) begin
                cnt_d  = '0;
                tgl_d  = ~tgl_q;
                rise_d = ~tgl_q;
                fall_d = tgl_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tgl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tgl_q  <= tgl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/stop FSM, one-deep pending cfg, commits new N only at a clk_out fall.
// Latency: all outputs registered; cfg_ready drops while a pending cfg is held.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] cur_half
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_ready_q;
    logic             cfg_err_q;
    logic             busy_q;

    logic             hs, hs_ok;
    logic             core_run, core_clear, core_wrap, core_clk;
    logic [CNT_W-1:0] core_half;
    logic             fall_wrap;

    assign hs        = cfg_valid & cfg_ready_q;
    assign hs_ok     = hs & (cfg_half != '0);
    assign fall_wrap = core_wrap & core_clk;

    // A cfg taken while stopped must already govern the first low phase.
    assign core_half = (state_q == STOP && hs_ok) ? cfg_half : cur_half_q;

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk       (clk),
        .rst       (rst),
        .run_i     (core_run),
        .clear_i   (core_clear),
        .half_i    (core_half),
        .wrap_o    (core_wrap),
        .clk_out_o (core_clk),
        .rise_o    (rise_pulse),
        .fall_o    (fall_pulse)
    );

    always_comb begin
        state_d    = state_q;
        cur_half_d = cur_half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        core_run   = 1'b0;
        core_clear = 1'b0;
        unique case (state_q)
            STOP: begin
                if (hs_ok) cur_half_d = cfg_half;
                if (en) begin
                    core_run = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN, PEND, DRAIN: begin
                // cfg_ready is low while pending is held, so a handshake implies it was empty.
                if (hs_ok) begin
                    pend_d     = cfg_half;
                    pend_vld_d = 1'b1;
                end
                if (!en && !core_clk) begin
                    core_clear = 1'b1;
                    state_d    = STOP;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q)  cur_half_d = pend_q;
                    else if (hs_ok)  cur_half_d = cfg_half;
                end else begin
                    core_run = 1'b1;
                    if (fall_wrap && pend_vld_q) begin
                        cur_half_d = pend_q;
                        pend_vld_d = 1'b0;
                    end
                    if (fall_wrap && !en) begin
                        state_d    = STOP;
                        pend_vld_d = 1'b0;
                        if (hs_ok) cur_half_d = cfg_half;
                    end else if (!en) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = pend_vld_d ? PEND : RUN;
                    end
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STOP;
            cur_half_q  <= HALF_RST;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_half_q  <= cur_half_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            cfg_ready_q <= ~pend_vld_d;
            cfg_err_q   <= hs & (cfg_half == '0);
            busy_q      <= (state_d != STOP);
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = core_clk;
    assign busy      = busy_q;
    assign cur_half  = cur_half_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed and randomized bench for clk_div_ctrl against a phase-level reference model.
module tb_clk_div_ctrl;

    localparam int CW = 16;
    localparam int DH = 2;

    logic          clk = 1'b0;
    logic          rst, en, cfg_valid;
    logic [CW-1:0] cfg_half;
    logic          cfg_ready, cfg_err, clk_out, rise_pulse, fall_pulse, busy;
    logic [CW-1:0] cur_half;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.CNT_W(CW), .DEFAULT_HALF(DH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_half   (cfg_half),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .cur_half   (cur_half)
    );

    // Reference: level of clk_out, cycles left in the current phase, queue of waiting settings.
    bit m_clk, m_rise, m_fall, m_err, m_active;
    int m_half = DH;
    int m_left = 0;
    int pend[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit had, output bit fell);
        fell = 1'b0;
        if (m_left == 1) begin
            m_clk = !m_clk;
            if (m_clk) m_rise = 1'b1;
            else begin
                m_fall = 1'b1;
                fell   = 1'b1;
            end
            if (fell && had) m_half = pend.pop_front();
            m_left = m_half;
        end else begin
            m_left--;
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v, input int d);
        bit hs, ok, had, fell;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_clk    = 1'b0;
            m_active = 1'b0;
            m_half   = DH;
            m_left   = 0;
            pend.delete();
        end else begin
            hs    = v && (pend.size() == 0);
            ok    = hs && (d != 0);
            m_err = hs && (d == 0);
            had   = (pend.size() != 0);
            if (!m_active) begin
                if (ok) m_half = d;
                if (e) begin
                    m_active = 1'b1;
                    m_left   = m_half;
                    tick(1'b0, fell);
                end
            end else begin
                if (ok) pend.push_back(d);
                if (!e && !m_clk) begin
                    m_active = 1'b0;
                    if (pend.size() != 0) m_half = pend.pop_front();
                end else begin
                    tick(had, fell);
                    if (fell && !e) begin
                        m_active = 1'b0;
                        if (pend.size() != 0) m_half = pend.pop_front();
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit v, input int d);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_half  = CW'(d);
        @(posedge clk);
        model_step(r, e, v, d);
        #1;
        chk("clk_out", clk_out, m_clk);
        chk("rise", rise_pulse, m_rise);
        chk("fall", fall_pulse, m_fall);
        chk("err", cfg_err, m_err);
        chk("busy", busy, m_active);
        chk("ready", cfg_ready, pend.size() == 0);
        chk("half", cur_half, m_half);
    endtask

    task automatic wait_rise();
        int n = 0;
        do begin
            cyc(0, 1, 0, 0);
            n++;
        end while (!rise_pulse && n < 64);
        chk("wait_rise", rise_pulse, 1);
    endtask

    task automatic stop_all();
        int n = 0;
        do begin
            cyc(0, 0, 0, 0);
            n++;
        end while (busy && n < 64);
        chk("stop_busy", busy, 0);
    endtask

    initial begin
        bit r_e, r_v, r_r;
        int r_d;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_half", cur_half, DH);
        chk("rst_busy", busy, 0);

        // Default N=2: rise two cycles after en
        cyc(0, 1, 0, 0);
        chk("t1_low", clk_out, 0);
        cyc(0, 1, 0, 0);
        chk("t1_rise", rise_pulse, 1);
        repeat (10) cyc(0, 1, 0, 0);
        stop_all();

        // Load 5 while stopped, then run
        cyc(0, 0, 1, 5);
        chk("t2_half", cur_half, 5);
        repeat (4) cyc(0, 1, 0, 0);
        chk("t2_low", clk_out, 0);
        cyc(0, 1, 0, 0);
        chk("t2_rise", rise_pulse, 1);
        repeat (20) cyc(0, 1, 0, 0);
        stop_all();

        // N=3, reprogram to 1 during high phase
        cyc(0, 0, 1, 3);
        wait_rise();
        cyc(0, 1, 1, 1);
        chk("t3_ready_lo", cfg_ready, 0);
        cyc(0, 1, 0, 0);
        chk("t3_still_hi", clk_out, 1);
        chk("t3_old_half", cur_half, 3);
        cyc(0, 1, 0, 0);
        chk("t3_fall", fall_pulse, 1);
        chk("t3_new_half", cur_half, 1);
        cyc(0, 1, 0, 0);
        chk("t3_short_low", rise_pulse, 1);
        repeat (6) cyc(0, 1, 0, 0);

        // Reprogram to 4, then drop en one cycle into a high phase
        cyc(0, 1, 1, 4);
        repeat (6) cyc(0, 1, 0, 0);
        wait_rise();
        chk("t4_half", cur_half, 4);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_drain_hi1", clk_out, 1);
        cyc(0, 0, 0, 0);
        chk("t4_drain_hi2", clk_out, 1);
        cyc(0, 0, 0, 0);
        chk("t4_fall", fall_pulse, 1);
        chk("t4_idle", busy, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("t4_held_lo", clk_out, 0);

        // Zero half-period is rejected
        wait_rise();
        cyc(0, 1, 1, 0);
        chk("t5_err", cfg_err, 1);
        cyc(0, 1, 0, 0);
        chk("t5_err_once", cfg_err, 0);
        chk("t5_half", cur_half, 4);
        repeat (6) cyc(0, 1, 0, 0);

        // Reset drops a held pending setting
        cyc(0, 1, 1, 7);
        chk("t6_pend", cfg_ready, 0);
        cyc(1, 1, 0, 0);
        chk("t6_clk_out", clk_out, 0);
        chk("t6_half", cur_half, DH);
        chk("t6_ready", cfg_ready, 1);
        chk("t6_busy", busy, 0);
        repeat (20) cyc(0, 0, 0, 0);
        chk("t6_no_seven", cur_half, DH);

        // Randomized traffic
        r_e = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) r_e = !r_e;
            r_v = ($urandom_range(0, 5) == 0);
            r_d = int'($urandom_range(0, 6));
            r_r = ($urandom_range(0, 499) == 0);
            cyc(r_r, r_e, r_v, r_d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
